demux_16_reg: RTL and testbench
===============================

Name: demux_16_reg

Overview:
- Registered 1-to-16 distributor. It is the write-side counterpart of the 16:1 select mux used in the message decoder datapath.
- Accepts N-bit words over a valid/ready handshake and stores each word into one of 16 holding lanes. The target lane is either the explicit select S or an internal auto-increment pointer.
- Each lane raises a sticky valid flag that the consumer clears per lane with ack, so words are never overwritten before they are consumed.

Parameters:
- N, 4, data width of the input word and of each lane.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- D  input  N  input data word.
- S  input  4  explicit target lane. Used only when auto_mode=0.
- auto_mode  input  1  1 = target lane is the internal pointer; 0 = target lane is S.
- in_valid  input  1  producer has a word on D.
- in_ready  output  1  target lane can accept a word this cycle (combinational).
- ack  input  16  per-lane consume strobe. Bit i clears lane_valid[i].
- clear  input  1  synchronous flush of all valid flags and the pointer.
- Y00..Y15  output  N each  registered lane contents.
- lane_valid  output  16  per-lane sticky valid flags.
- ptr  output  4  current auto-increment pointer.
- count  output  5  number of set lane_valid bits, range 0..16.
- full  output  1  all 16 lanes valid.
- empty  output  1  no lane valid.

Behaviour:
- Reset (asynchronous, rst=1): Y00..Y15=0, lane_valid=0, ptr=0, count=0, full=0, empty=1. The only clock and reset are clk and rst, as fixed above.
- Target lane: tgt = auto_mode ? ptr : S.
- in_ready = ~clear & ~lane_valid[tgt]. It is purely combinational from registered state and the select inputs.
- Accept: occurs when in_valid & in_ready at a rising edge. On that edge:
  - Y[tgt] <= D and lane_valid[tgt] <= 1.
  - If auto_mode=1, ptr <= ptr+1, wrapping 15 -> 0.
  - Y and lane_valid are visible the cycle after the accept (1-cycle latency).
- No accept: Y, lane_valid and ptr hold.
- Pointer with auto_mode=0: ptr holds its value. Switching modes mid-stream neither resets nor advances ptr.
- ack[i]=1: lane_valid[i] <= 0 on the next edge. Y[i] keeps its data.
  - ack on a lane that is not valid is a no-op.
  - Multiple ack bits in the same cycle are legal.
- Same-lane ack and write in one cycle: cannot happen, because in_ready=0 while the lane is valid. The ack clears the lane and the write is accepted on a later cycle once the producer sees in_ready=1.
- Ack of lane j while writing lane k (j != k): both take effect on the same edge.
- clear=1 (synchronous):
  - lane_valid <= 0 and ptr <= 0.
  - Y retains its values.
  - in_ready is forced to 0, so no accept occurs. clear has priority over both writes and ack.
- Status outputs: count, full and empty are registered and consistent with lane_valid in the same cycle.
  - count is updated as count + accept − (number of acked lanes that were valid).
  - full = (count==16); empty = (count==0).
- Full condition: in_ready=0 for every tgt. The producer stalls, and no data is lost or overwritten.
- Auto-mode wrap: after lane 15 is written, ptr=0. If lane 0 is still valid, the block stalls until ack[0].
- Reset mid-transfer: state goes to reset values immediately (asynchronous). A word presented in the reset cycle is dropped.

Decomposition:
- Package demux_pkg:
  - constants LANES=16, SEL_W=4, CNT_W=5.
  - typedef sel_t (logic [SEL_W-1:0]).
  - typedef lane_mask_t (logic [LANES-1:0]).
- Sub-module demux_lane #(N): a single lane holding its data register and valid flag. It has inputs we, ack, clear, d and outputs q, v. It is instantiated 16 times via generate.
- The top level holds the pointer, count, the target decode and in_ready.

Test Plan (N=4):
- Reset -> all Y=0, lane_valid=0, count=0, empty=1, in_ready=1. Assert rst mid-stream -> same values in the same cycle.
- auto_mode=1, write D=1..16 (4-bit wrap, so 16 -> 0) over 16 cycles with no ack -> Y00..Y15 = 1..15,0; full=1, count=16, ptr=0, in_ready=0; a 17th in_valid is not accepted.
- auto_mode=0, S=5, D=A -> Y05=A one cycle later, lane_valid=0x0020. A second write to S=5 stalls until ack[5]=1; it is accepted the cycle after lane_valid[5] drops.
- ack=0x0021 with only lane 5 valid -> lane_valid=0, count=0; ack[0] is a no-op; Y05 still equals A.
- Same cycle: write S=3, D=7 and ack[9] (lane 9 valid) -> lane_valid has bit 3 set and bit 9 cleared, count unchanged.
- clear with lanes 2 and 4 valid, ptr=6, in_valid=1 -> lane_valid=0, ptr=0, count=0, no write, Y02/Y04 retained.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 16-lane registered distributor.
package demux_pkg;
    localparam int LANES = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 5;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t popcount(input lane_mask_t m);
        cnt_t c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + cnt_t'(m[i]);
        return c;
    endfunction
endpackage

// File: rtl/demux_lane.sv
// One holding lane: data register plus sticky valid flag.
module demux_lane #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic         ack,
    input  logic         clear,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         v
);
    logic [N-1:0] data_q, data_d;
    logic         vld_q, vld_d;

    // clear outranks a write; data is kept across clear so only the flag drops
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clear)    vld_d = 1'b0;
        else if (we)  vld_d = 1'b1;
        else if (ack) vld_d = 1'b0;
        if (we && !clear) data_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q = data_q;
    assign v = vld_q;
endmodule

// File: rtl/demux_16_reg.sv
// Registered 1-to-16 distributor: valid/ready input, per-lane sticky valid with ack.
module demux_16_reg
    import demux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic [3:0]   S,
    input  logic         auto_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  ack,
    input  logic         clear,
    output logic [N-1:0] Y00,
    output logic [N-1:0] Y01,
    output logic [N-1:0] Y02,
    output logic [N-1:0] Y03,
    output logic [N-1:0] Y04,
    output logic [N-1:0] Y05,
    output logic [N-1:0] Y06,
    output logic [N-1:0] Y07,
    output logic [N-1:0] Y08,
    output logic [N-1:0] Y09,
    output logic [N-1:0] Y10,
    output logic [N-1:0] Y11,
    output logic [N-1:0] Y12,
    output logic [N-1:0] Y13,
    output logic [N-1:0] Y14,
    output logic [N-1:0] Y15,
    output logic [15:0]  lane_valid,
    output logic [3:0]   ptr,
    output logic [4:0]   count,
    output logic         full,
    output logic         empty
);
    sel_t       ptr_q, ptr_d, tgt;
    cnt_t       count_q, count_d;
    logic       full_q, empty_q;
    logic       accept;
    lane_mask_t we_mask, ack_eff, vld;
    logic [N-1:0] y_w [LANES];

    assign tgt      = auto_mode ? ptr_q : S;
    assign in_ready = ~clear & ~vld[tgt];
    assign accept   = in_valid & in_ready;
    assign we_mask  = accept ? (lane_mask_t'(1) << tgt) : '0;
    // only acks that actually drop a set flag move the count
    assign ack_eff  = ack & vld & {LANES{~clear}};

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q + cnt_t'(accept) - popcount(ack_eff);
        if (clear) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (accept && auto_mode) begin
            ptr_d = ptr_q + sel_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= (count_d == cnt_t'(LANES));
            empty_q <= (count_d == '0);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(.N(N)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (we_mask[i]),
            .ack   (ack[i]),
            .clear (clear),
            .d     (D),
            .q     (y_w[i]),
            .v     (vld[i])
        );
    end

    assign lane_valid = vld;
    assign ptr        = ptr_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;

    assign Y00 = y_w[0];
    assign Y01 = y_w[1];
    assign Y02 = y_w[2];
    assign Y03 = y_w[3];
    assign Y04 = y_w[4];
    assign Y05 = y_w[5];
    assign Y06 = y_w[6];
    assign Y07 = y_w[7];
    assign Y08 = y_w[8];
    assign Y09 = y_w[9];
    assign Y10 = y_w[10];
    assign Y11 = y_w[11];
    assign Y12 = y_w[12];
    assign Y13 = y_w[13];
    assign Y14 = y_w[14];
    assign Y15 = y_w[15];
endmodule

// File: tb/tb_demux_16_reg.sv
// Directed + random bench for demux_16_reg against a lane-array reference model.
module tb_demux_16_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D, S;
    logic        auto_mode, in_valid, clear;
    logic [15:0] ack;
    logic        in_ready;
    logic [3:0]  Y00, Y01, Y02, Y03, Y04, Y05, Y06, Y07;
    logic [3:0]  Y08, Y09, Y10, Y11, Y12, Y13, Y14, Y15;
    logic [15:0] lane_valid;
    logic [3:0]  ptr;
    logic [4:0]  count;
    logic        full, empty;

    int total = 0;
    int bad   = 0;

    logic [3:0] mmem [16];
    bit         mv   [16];
    int         mptr;

    wire [15:0][3:0] yv = {Y15, Y14, Y13, Y12, Y11, Y10, Y09, Y08,
                           Y07, Y06, Y05, Y04, Y03, Y02, Y01, Y00};

    demux_16_reg #(.N(4)) dut (
        .clk(clk), .rst(rst), .D(D), .S(S), .auto_mode(auto_mode),
        .in_valid(in_valid), .in_ready(in_ready), .ack(ack), .clear(clear),
        .Y00(Y00), .Y01(Y01), .Y02(Y02), .Y03(Y03), .Y04(Y04), .Y05(Y05),
        .Y06(Y06), .Y07(Y07), .Y08(Y08), .Y09(Y09), .Y10(Y10), .Y11(Y11),
        .Y12(Y12), .Y13(Y13), .Y14(Y14), .Y15(Y15),
        .lane_valid(lane_valid), .ptr(ptr), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mmask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = mv[i];
        return m;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 16; i++) if (mv[i]) c++;
        return c;
    endfunction

    function automatic bit mready();
        int t = auto_mode ? mptr : int'(S);
        return !clear && !mv[t];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin mmem[i] = '0; mv[i] = 0; end
        mptr = 0;
    endtask

    task automatic chk_all();
        for (int i = 0; i < 16; i++) chk($sformatf("Y%0d", i), yv[i], mmem[i]);
        chk("lane_valid", lane_valid, mmask());
        chk("ptr", ptr, mptr);
        chk("count", count, mcount());
        chk("full", full, mcount() == 16);
        chk("empty", empty, mcount() == 0);
    endtask

    // one clock: check ready, advance model with the same inputs, check state
    task automatic step();
        int  t;
        bit  rdy;
        #1;
        rdy = mready();
        t   = auto_mode ? mptr : int'(S);
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (clear) begin
            for (int i = 0; i < 16; i++) mv[i] = 0;
            mptr = 0;
        end else begin
            for (int i = 0; i < 16; i++) if (ack[i]) mv[i] = 0;
            if (in_valid && rdy) begin
                mmem[t] = D;
                mv[t]   = 1;
                if (auto_mode) mptr = (mptr + 1) % 16;
            end
        end
        #1;
        chk_all();
    endtask

    task automatic idle();
        in_valid = 0; ack = '0; clear = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        chk_all();
        @(posedge clk);
        #1;
        rst = 0;
        chk_all();
    endtask

    initial begin
        rst = 1; D = '0; S = '0; auto_mode = 0; in_valid = 0; ack = '0; clear = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk_all();
        rst = 0;
        #1;
        chk("reset_ready", in_ready, 1);

        // auto fill 1..16 (wraps to 0) then a 17th word must stall
        auto_mode = 1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; D = 4'(i);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_Y15", Y15, 0);
        D = 4'h9;
        step();
        chk("fill_17th_Y00", Y00, 1);

        // explicit lane 5, blocked second write, ack unblocks
        idle(); clear = 1; step();
        idle(); auto_mode = 0; S = 5; D = 4'hA; in_valid = 1; step();
        chk("lane5_mask", lane_valid, 16'h0020);
        D = 4'h3; step(); step();
        chk("lane5_held", Y05, 4'hA);
        ack = 16'h0020; step();
        ack = '0; step();
        chk("lane5_second", Y05, 4'h3);

        // ack with an invalid lane bit mixed in
        idle(); ack = 16'h0021; step();
        chk("ack_mask", lane_valid, 16'h0000);
        chk("ack_keepY", Y05, 4'h3);

        // write lane 3 while acking lane 9
        idle(); S = 9; D = 4'h6; in_valid = 1; step();
        S = 3; D = 4'h7; ack = 16'h0200; step();
        chk("wr_ack_mask", lane_valid, 16'h0008);
        chk("wr_ack_count", count, 1);

        // clear with lanes 2 and 4 valid, ptr 6, write pending
        idle(); clear = 1; step();
        idle(); auto_mode = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; D = 4'(i + 8); step();
        end
        idle(); ack = 16'h002B; step();
        chk("pre_clear_mask", lane_valid, 16'h0014);
        idle(); clear = 1; in_valid = 1; D = 4'hF; step();
        chk("clr_ptr", ptr, 0);
        chk("clr_Y02", Y02, 4'hA);
        chk("clr_Y04", Y04, 4'hC);

        // random traffic with one mid-stream reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                in_valid = 1; D = 4'h5;
                do_reset();
            end
            D         = 4'($urandom);
            S         = 4'($urandom);
            auto_mode = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            ack       = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
            clear     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
